// File: rtl/fifo_lookahead_ctrl_pkg.sv
// Shared definitions for the look-ahead FIFO controller and its RAM.
package fifo_lookahead_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 3;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned AFULL_TH_DEF   = 6;
  localparam int unsigned AEMPTY_TH_DEF  = 1;

  // Number of words popped in one cycle; rd2 outranks rd.
  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_e;

  // Occupancy flags decoded from the level register.
  typedef struct packed {
    logic empty;
    logic full;
    logic valid2;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  // FIFO depth for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/fifo_lookahead_ctrl_if.sv
// Handshake/status bundle between producer/consumer logic and the controller.
interface fifo_lookahead_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = fifo_lookahead_ctrl_pkg::ADDR_WIDTH_DEF
);

  logic                  wr;
  logic                  rd;
  logic                  rd2;
  logic                  clr_err;
  logic                  we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [ADDR_WIDTH:0]   level;
  logic                  empty;
  logic                  full;
  logic                  valid2;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  // Producer/consumer side.
  modport master (
    output wr, rd, rd2, clr_err,
    input  we, w_addr, r_addr0, r_addr1, level, empty, full, valid2,
           almost_full, almost_empty, overflow, underflow
  );

  // Controller side.
  modport slave (
    input  wr, rd, rd2, clr_err,
    output we, w_addr, r_addr0, r_addr1, level, empty, full, valid2,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_lookahead_ctrl_ram.sv
// 1-write/2-read register-file RAM: synchronous write, combinational reads.
module fifo_lookahead_ctrl_ram
  import fifo_lookahead_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic [ADDR_WIDTH-1:0] r_addr0_i,
  input  logic [ADDR_WIDTH-1:0] r_addr1_i,
  output logic [DATA_WIDTH-1:0] r_data0_o,
  output logic [DATA_WIDTH-1:0] r_data1_o
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is not reset; the controller's level decides which words are live.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  // Reads are combinational, with no write-through bypass.
  assign r_data0_o = mem_q[r_addr0_i];
  assign r_data1_o = mem_q[r_addr1_i];

endmodule

// File: rtl/fifo_lookahead_ctrl.sv
// Pointer/flag controller running a 1W/2R register file as a circular FIFO
// whose head and head+1 words are both visible for single or double pops.
module fifo_lookahead_ctrl
  import fifo_lookahead_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned AFULL_TH   = AFULL_TH_DEF,
  parameter int unsigned AEMPTY_TH  = AEMPTY_TH_DEF
) (
  input logic                 clk,
  input logic                 reset_n,
  fifo_lookahead_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned LW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  pop_e                  pop_req;
  logic [LW-1:0]         n_req;
  logic [LW-1:0]         n_acc;
  logic                  pop_rej;
  logic                  pop_ok;
  logic                  push_ok;
  flags_t                flags;

  // Pop request encoding and all-or-nothing accept decision.
  always_comb begin
    pop_req = POP_NONE;
    if (bus.rd2) begin
      pop_req = POP_TWO;
    end else if (bus.rd) begin
      pop_req = POP_ONE;
    end
    n_req   = LW'(pop_req);
    pop_rej = (pop_req != POP_NONE) && (n_req > level_q);
    pop_ok  = (pop_req != POP_NONE) && !pop_rej;
    n_acc   = pop_ok ? n_req : '0;
  end

  // A push into a full FIFO only fits if a pop frees room in the same cycle.
  always_comb begin
    push_ok = bus.wr && ((level_q - n_acc) < LW'(DEPTH));
  end

  // Next pointer, level and sticky error state.
  always_comb begin
    head_d  = head_q + ADDR_WIDTH'(n_acc);
    tail_d  = tail_q + ADDR_WIDTH'(push_ok);
    level_d = level_q + LW'(push_ok) - n_acc;

    ovf_d = ovf_q;
    if (bus.wr && !push_ok) begin
      ovf_d = 1'b1;
    end else if (bus.clr_err) begin
      ovf_d = 1'b0;
    end

    udf_d = udf_q;
    if (pop_rej) begin
      udf_d = 1'b1;
    end else if (bus.clr_err) begin
      udf_d = 1'b0;
    end
  end

  // State registers; reset drops pointers only, RAM contents are left alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Flags are a pure decode of the registered level.
  always_comb begin
    flags              = '0;
    flags.empty        = (level_q == '0);
    flags.full         = (level_q == LW'(DEPTH));
    flags.valid2       = (level_q >= LW'(2));
    flags.almost_full  = (level_q >= LW'(AFULL_TH));
    flags.almost_empty = (level_q <= LW'(AEMPTY_TH));
  end

  assign bus.we           = push_ok;
  assign bus.w_addr       = tail_q;
  assign bus.r_addr0      = head_q;
  assign bus.r_addr1      = head_q + ADDR_WIDTH'(1);
  assign bus.level        = level_q;
  assign bus.empty        = flags.empty;
  assign bus.full         = flags.full;
  assign bus.valid2       = flags.valid2;
  assign bus.almost_full  = flags.almost_full;
  assign bus.almost_empty = flags.almost_empty;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_lookahead_ctrl.sv
// Bench for the look-ahead FIFO controller paired with its register-file RAM.
module tb_fifo_lookahead_ctrl;
  import fifo_lookahead_ctrl_pkg::*;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data0;
  logic [DW-1:0] r_data1;

  always #5 clk = ~clk;

  fifo_lookahead_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_lookahead_ctrl #(.ADDR_WIDTH(AW), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  fifo_lookahead_ctrl_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram (
    .clk       (clk),
    .we_i      (bus.we),
    .w_addr_i  (bus.w_addr),
    .w_data_i  (w_data),
    .r_addr0_i (bus.r_addr0),
    .r_addr1_i (bus.r_addr1),
    .r_data0_o (r_data0),
    .r_data1_o (r_data1)
  );

  typedef struct {
    logic          wr;
    logic          rd;
    logic          rd2;
    logic          clr;
    logic [DW-1:0] data;
    logic          exp_we;
    logic [AW-1:0] exp_waddr;
    int            exp_level;
    logic          exp_ovf;
    logic          exp_udf;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic rd2, input logic clr,
                     input logic [DW-1:0] d, input logic we, input logic [AW-1:0] wa,
                     input int lvl, input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.rd2 = rd2; v.clr = clr; v.data = d;
    v.exp_we = we; v.exp_waddr = wa; v.exp_level = lvl;
    v.exp_ovf = ovf; v.exp_udf = udf;
    vecs.push_back(v);
  endtask

  task automatic check_flags(input string tag, input int lvl);
    check({tag, ".level"},  int'(bus.level), lvl);
    check({tag, ".empty"},  int'(bus.empty), int'(lvl == 0));
    check({tag, ".full"},   int'(bus.full), int'(lvl == 8));
    check({tag, ".valid2"}, int'(bus.valid2), int'(lvl >= 2));
    check({tag, ".afull"},  int'(bus.almost_full), int'(lvl >= 6));
    check({tag, ".aempty"}, int'(bus.almost_empty), int'(lvl <= 1));
  endtask

  // Drive one vector, check combinational outputs and head data, then the post-edge state.
  task automatic apply(input vec_t v, input int idx);
    int   n;
    int   n_acc;
    logic pop_ok;
    logic push_ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    bus.wr = v.wr; bus.rd = v.rd; bus.rd2 = v.rd2; bus.clr_err = v.clr;
    w_data = v.data;
    #1;
    check({tag, ".we"},     int'(bus.we), int'(v.exp_we));
    check({tag, ".w_addr"}, int'(bus.w_addr), int'(v.exp_waddr));
    n      = v.rd2 ? 2 : (v.rd ? 1 : 0);
    pop_ok = (n > 0) && (n <= sb.size());
    n_acc  = pop_ok ? n : 0;
    push_ok = v.wr && ((sb.size() - n_acc) < 8);
    if (pop_ok) begin
      check({tag, ".r_data0"}, int'(r_data0), int'(sb[0]));
      if (n == 2) check({tag, ".r_data1"}, int'(r_data1), int'(sb[1]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < n_acc; k++) void'(sb.pop_front());
    if (push_ok) sb.push_back(v.data);
    check_flags(tag, v.exp_level);
    check({tag, ".overflow"},  int'(bus.overflow), int'(v.exp_ovf));
    check({tag, ".underflow"}, int'(bus.underflow), int'(v.exp_udf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr = 1'b0; bus.rd = 1'b0; bus.rd2 = 1'b0; bus.clr_err = 1'b0;
    w_data = '0;

    // Fill to full, then reject a ninth push.
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 0, 8'hA0 + DW'(i), 1, AW'(i), i + 1, 0, 0);
    add(1, 0, 0, 0, 8'hA8, 0, 3'd0, 8, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 3'd0, 8, 1, 0);
    add(0, 0, 0, 1, 8'h00, 0, 3'd0, 8, 0, 0);
    // Drain by pairs.
    for (int i = 0; i < 4; i++)
      add(0, 0, 1, 0, 8'h00, 0, 3'd0, 6 - 2 * i, 0, 0);
    // Double pop with one word is rejected whole; single pop then succeeds.
    add(1, 0, 0, 0, 8'hB0, 1, 3'd0, 1, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 3'd1, 1, 0, 1);
    add(0, 1, 0, 0, 8'h00, 0, 3'd1, 0, 0, 1);
    add(0, 0, 0, 1, 8'h00, 0, 3'd1, 0, 0, 0);
    // Push+pop on empty: push wins, pop underflows.
    add(1, 1, 0, 0, 8'hC0, 1, 3'd1, 1, 0, 1);
    add(0, 0, 0, 1, 8'h00, 0, 3'd2, 1, 0, 0);
    // Refill to full across the address wrap.
    for (int i = 0; i < 7; i++)
      add(1, 0, 0, 0, 8'hD0 + DW'(i), 1, AW'(2 + i), 2 + i, 0, 0);
    // Push+pop while full, tail walking 1..7 then wrapping to 0.
    for (int i = 0; i < 8; i++)
      add(1, 1, 0, 0, 8'hE0 + DW'(i), 1, AW'(1 + i), 8, 0, 0);
    add(1, 0, 1, 0, 8'hF0, 1, 3'd1, 7, 0, 0);
    add(1, 0, 0, 0, 8'hF1, 1, 3'd2, 8, 0, 0);
    // New overflow beats clr_err in the same cycle.
    add(1, 0, 0, 1, 8'hF2, 0, 3'd3, 8, 1, 0);
    add(0, 0, 0, 1, 8'h00, 0, 3'd3, 8, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 1, 0, 8'h00, 0, 3'd3, 6 - 2 * i, 0, 0);
    // New underflow beats clr_err in the same cycle.
    add(0, 1, 0, 1, 8'h00, 0, 3'd3, 0, 0, 1);
    add(0, 0, 0, 1, 8'h00, 0, 3'd3, 0, 0, 0);

    // Reset state.
    #12;
    check("rst.r_addr0", int'(bus.r_addr0), 0);
    check("rst.r_addr1", int'(bus.r_addr1), 1);
    check("rst.w_addr",  int'(bus.w_addr), 0);
    check("rst.we",      int'(bus.we), 0);
    check("rst.ovf",     int'(bus.overflow), 0);
    check("rst.udf",     int'(bus.underflow), 0);
    check_flags("rst", 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset in the middle of a burst at level 5.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.wr = 1'b1; bus.rd = 1'b0; bus.rd2 = 1'b0; bus.clr_err = 1'b0;
      w_data = 8'h50 + DW'(i);
    end
    @(negedge clk);
    bus.wr = 1'b0;
    #1;
    check("burst.level", int'(bus.level), 5);
    check("burst.r_data0", int'(r_data0), 8'h50);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.level",   int'(bus.level), 0);
    check("arst.empty",   int'(bus.empty), 1);
    check("arst.r_addr0", int'(bus.r_addr0), 0);
    check("arst.r_addr1", int'(bus.r_addr1), 1);
    check("arst.w_addr",  int'(bus.w_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();

    // First push after reset is visible at the head one cycle later.
    @(negedge clk);
    bus.wr = 1'b1;
    w_data = 8'h77;
    @(negedge clk);
    bus.wr = 1'b0;
    #1;
    check("post.level",   int'(bus.level), 1);
    check("post.r_data0", int'(r_data0), 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
